// File: rtl/card_game_fsm.sv
// Arithmetic card game controller: pick a card, an operator and a second card; reduce to one card and compare it with TARGET.
// Optional one-level undo is compiled in when CARD_GAME_UNDO_EN is defined.
module card_game_fsm #(
  parameter int NUM_CARDS = 4,
  parameter int WIDTH     = 10,
  parameter int TARGET    = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       restart,
  input  logic [3:0]                 key,
  input  logic [NUM_CARDS*WIDTH-1:0] deal,
  output logic [NUM_CARDS*WIDTH-1:0] nums,
  output logic [NUM_CARDS-1:0]       valid,
  output logic                       win,
  output logic                       lose,
  output logic                       err
);

  localparam int IDX_W = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] PICK_A  = 3'd1;
  localparam logic [2:0] PICK_OP = 3'd2;
  localparam logic [2:0] PICK_B  = 3'd3;
  localparam logic [2:0] EXEC    = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam logic [3:0] KEY_ADD  = 4'hA;
  localparam logic [3:0] KEY_SUB  = 4'hB;
  localparam logic [3:0] KEY_MUL  = 4'hC;
  localparam logic [3:0] KEY_DIV  = 4'hD;
  localparam logic [3:0] KEY_UNDO = 4'hE;

  logic [2:0]       state;
  logic             start_q, restart_q;
  logic [3:0]       key_q;
  logic [WIDTH-1:0] cards [NUM_CARDS];
  logic [WIDTH-1:0] snap  [NUM_CARDS];
  logic [IDX_W-1:0] a_idx, b_idx;
  logic [3:0]       op;

  logic             start_ev, restart_ev, key_ev;
  logic             is_card, card_ok, is_op;
  logic [IDX_W-1:0] sel_idx, lo_idx, hi_idx;
  logic [WIDTH-1:0] a_val, b_val, result;
  logic             div_zero, one_left;
  logic [NUM_CARDS-1:0] valid_after;

  for (genvar i = 0; i < NUM_CARDS; i++) begin : g_nums
    assign nums[i*WIDTH +: WIDTH] = cards[i];
  end

  // Events come from the previous-cycle copies, so held keys never repeat.
  assign start_ev   = start & ~start_q;
  assign restart_ev = restart & ~restart_q & (state != IDLE);
  assign key_ev     = (key != 4'h0) && (key_q == 4'h0);

  assign is_card = (key != 4'h0) && (key <= 4'(NUM_CARDS));
  assign sel_idx = IDX_W'(key - 4'd1);
  assign card_ok = is_card && valid[sel_idx];
  assign is_op   = (key >= KEY_ADD) && (key <= KEY_DIV);

  assign a_val       = cards[a_idx];
  assign b_val       = cards[b_idx];
  assign div_zero    = (op == KEY_DIV) && (b_val == '0);
  assign lo_idx      = (a_idx < b_idx) ? a_idx : b_idx;
  assign hi_idx      = (a_idx < b_idx) ? b_idx : a_idx;
  assign valid_after = valid & ~(NUM_CARDS'(1) << hi_idx);
  assign one_left    = ($countones(valid_after) == 1);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    result = '0;
    case (op)
      KEY_ADD: result = a_val + b_val;
      KEY_SUB: result = a_val - b_val;
      KEY_MUL: result = a_val * b_val;
      KEY_DIV: result = (b_val == '0) ? '0 : a_val / b_val;
      default: result = '0;
    endcase
  end

`ifdef CARD_GAME_UNDO_EN
  logic [WIDTH-1:0]     undo_cards [NUM_CARDS];
  logic [NUM_CARDS-1:0] undo_valid;
  logic                 undo_full;
  logic                 undo_ev;

  assign undo_ev = key_ev && (key == KEY_UNDO) &&
                   (state inside {PICK_A, PICK_OP, PICK_B, DONE});
`endif

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      restart_q <= 1'b0;
      key_q     <= 4'h0;
      valid     <= '0;
      win       <= 1'b0;
      lose      <= 1'b0;
      err       <= 1'b0;
      a_idx     <= '0;
      b_idx     <= '0;
      op        <= 4'h0;
      // NOTE: the card arrays are small register files and are cleared on reset, unlike RAM.
      for (int i = 0; i < NUM_CARDS; i++) begin
        cards[i] <= '0;
        snap[i]  <= '0;
      end
`ifdef CARD_GAME_UNDO_EN
      for (int i = 0; i < NUM_CARDS; i++) undo_cards[i] <= '0;
      undo_valid <= '0;
      undo_full  <= 1'b0;
`endif
    end else begin
      start_q   <= start;
      restart_q <= restart;
      key_q     <= key;
      err       <= 1'b0;
      if (start_ev) begin
        for (int i = 0; i < NUM_CARDS; i++) begin
          cards[i] <= deal[i*WIDTH +: WIDTH];
          snap[i]  <= deal[i*WIDTH +: WIDTH];
        end
        valid <= '1;
        win   <= 1'b0;
        lose  <= 1'b0;
        state <= PICK_A;
`ifdef CARD_GAME_UNDO_EN
        undo_full <= 1'b0;
`endif
      end else if (restart_ev) begin
        for (int i = 0; i < NUM_CARDS; i++) cards[i] <= snap[i];
        valid <= '1;
        win   <= 1'b0;
        lose  <= 1'b0;
        state <= PICK_A;
`ifdef CARD_GAME_UNDO_EN
        undo_full <= 1'b0;
`endif
      end
`ifdef CARD_GAME_UNDO_EN
      else if (undo_ev) begin
        if (undo_full) begin
          for (int i = 0; i < NUM_CARDS; i++) cards[i] <= undo_cards[i];
          valid     <= undo_valid;
          win       <= 1'b0;
          lose      <= 1'b0;
          state     <= PICK_A;
          undo_full <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end
`endif
      else begin
        case (state)
          PICK_A: if (key_ev && card_ok) begin
            a_idx <= sel_idx;
            state <= PICK_OP;
          end
          PICK_OP: if (key_ev) begin
            if (is_op) begin
              op    <= key;
              state <= PICK_B;
            end else if (card_ok) begin
              a_idx <= sel_idx;
            end
          end
          PICK_B: if (key_ev) begin
            if (card_ok && (sel_idx != a_idx)) begin
              b_idx <= sel_idx;
              state <= EXEC;
            end else if (is_op) begin
              op <= key;
            end else if (is_card) begin
              err <= 1'b1;
            end
          end
          EXEC: begin
`ifdef CARD_GAME_UNDO_EN
            for (int i = 0; i < NUM_CARDS; i++) undo_cards[i] <= cards[i];
            undo_valid <= valid;
            undo_full  <= 1'b1;
`endif
            if (div_zero) begin
              err   <= 1'b1;
              state <= PICK_A;
            end else begin
              cards[lo_idx] <= result;
              valid         <= valid_after;
              if (one_left) begin
                state <= DONE;
                win   <= (result == WIDTH'(TARGET));
                lose  <= (result != WIDTH'(TARGET));
              end else begin
                state <= PICK_A;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_card_game_fsm.sv
// Directed, table-driven bench for card_game_fsm with default parameters (4 cards, 10-bit, target 24).
// Undo expectations switch on CARD_GAME_UNDO_EN.
module tb_card_game_fsm;

  localparam int NC = 4;
  localparam int W  = 10;

  logic            clk = 1'b0;
  logic            rst_n, start, restart;
  logic [3:0]      key;
  logic [NC*W-1:0] deal, nums;
  logic [NC-1:0]   valid;
  logic            win, lose, err;

  int checks = 0;
  int errors = 0;
  int err_total = 0;

  card_game_fsm dut (
    .clk(clk), .rst_n(rst_n), .start(start), .restart(restart), .key(key),
    .deal(deal), .nums(nums), .valid(valid), .win(win), .lose(lose), .err(err)
  );

  always #5 clk = ~clk;

  // err is a one-cycle pulse; count it mid-cycle.
  always @(negedge clk) if (err === 1'b1) err_total = err_total + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct packed {
    logic          do_start;
    logic          do_restart;
    logic [NC*W-1:0] deal;
    logic [15:0]   keys;      // key presses, low nibble first; zero nibbles skipped
    logic [NC*W-1:0] exp_nums;
    logic [NC-1:0] exp_valid;
    logic          exp_win;
    logic          exp_lose;
    logic [1:0]    exp_err;
  } vec_t;

  function automatic logic [NC*W-1:0] p4(input int c0, c1, c2, c3);
    return {10'(c3), 10'(c2), 10'(c1), 10'(c0)};
  endfunction

  function automatic vec_t mk(input logic s, r, input logic [NC*W-1:0] d,
                              input logic [15:0] k, input logic [NC*W-1:0] n,
                              input logic [3:0] v, input logic w, l,
                              input logic [1:0] e);
    vec_t t;
    t.do_start = s; t.do_restart = r; t.deal = d; t.keys = k;
    t.exp_nums = n; t.exp_valid = v; t.exp_win = w; t.exp_lose = l; t.exp_err = e;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key = k;
    tick();
    key = 4'h0;
    tick();
  endtask

  task automatic check_state(input string name, input logic [NC*W-1:0] n,
                             input logic [3:0] v, input logic w, l);
    check({name, ".nums"}, 64'(nums), 64'(n));
    check({name, ".valid"}, 64'(valid), 64'(v));
    check({name, ".win"}, 64'(win), 64'(w));
    check({name, ".lose"}, 64'(lose), 64'(l));
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int base;
    string nm;
    logic [3:0] kk;
    nm = $sformatf("vec%0d", idx);
    base = err_total;
    if (v.do_start) begin
      deal = v.deal; start = 1'b1; tick(); start = 1'b0; tick();
    end
    if (v.do_restart) begin
      restart = 1'b1; tick(); restart = 1'b0; tick();
    end
    for (int k = 0; k < 4; k++) begin
      kk = v.keys[k*4 +: 4];
      if (kk != 4'h0) press(kk);
    end
    tick();
    check_state(nm, v.exp_nums, v.exp_valid, v.exp_win, v.exp_lose);
    check({nm, ".err"}, 64'(err_total - base), 64'(v.exp_err));
  endtask

  vec_t vecs [24];

  initial begin
    int base;
    vecs[0]  = mk(1, 0, p4(4,6,1,1),   16'h02A1, p4(10,6,1,1),   4'b1101, 0, 0, 0);
    vecs[1]  = mk(0, 0, '0,            16'h04C3, p4(10,6,1,1),   4'b0101, 0, 0, 0);
    vecs[2]  = mk(1, 0, p4(8,3,3,0),   16'h03B2, p4(8,0,3,0),    4'b1011, 0, 0, 0);
    vecs[3]  = mk(0, 0, '0,            16'h02C1, p4(0,0,3,0),    4'b1001, 0, 0, 0);
    vecs[4]  = mk(0, 0, '0,            16'h04A1, p4(0,0,3,0),    4'b0001, 0, 1, 0);
    vecs[5]  = mk(1, 0, p4(6,4,0,0),   16'h04D1, p4(6,4,0,0),    4'b1111, 0, 0, 1);
    vecs[6]  = mk(1, 0, p4(2,3,4,0),   16'h03C2, p4(2,12,4,0),   4'b1011, 0, 0, 0);
    vecs[7]  = mk(0, 0, '0,            16'h02C1, p4(24,12,4,0),  4'b1001, 0, 0, 0);
    vecs[8]  = mk(0, 0, '0,            16'h04A1, p4(24,12,4,0),  4'b0001, 1, 0, 0);
    vecs[9]  = mk(0, 0, '0,            16'h04A1, p4(24,12,4,0),  4'b0001, 1, 0, 0);
    vecs[10] = mk(0, 1, '0,            16'h0000, p4(2,3,4,0),    4'b1111, 0, 0, 0);
    vecs[11] = mk(1, 0, p4(5,3,7,9),   16'h02B1, p4(2,3,7,9),    4'b1101, 0, 0, 0);
    vecs[12] = mk(1, 0, p4(3,5,0,0),   16'h02B1, p4(1022,5,0,0), 4'b1101, 0, 0, 0);
    vecs[13] = mk(1, 0, p4(7,2,0,0),   16'h01D2, p4(0,2,0,0),    4'b1101, 0, 0, 0);
    vecs[14] = mk(1, 0, p4(1000,1000,3,3), 16'h02A1, p4(976,1000,3,3), 4'b1101, 0, 0, 0);
    vecs[15] = mk(1, 0, p4(40,30,1,1), 16'h02C1, p4(176,30,1,1), 4'b1101, 0, 0, 0);
    vecs[16] = mk(1, 0, p4(1,2,3,4),   16'h01A1, p4(1,2,3,4),    4'b1111, 0, 0, 1);
    vecs[17] = mk(0, 0, '0,            16'h0002, p4(3,2,3,4),    4'b1101, 0, 0, 0);
    vecs[18] = mk(0, 0, '0,            16'h02A1, p4(3,2,3,4),    4'b1101, 0, 0, 1);
    vecs[19] = mk(0, 0, '0,            16'h0003, p4(6,2,3,4),    4'b1001, 0, 0, 0);
    vecs[20] = mk(1, 0, p4(9,2,5,1),   16'h4B31, p4(9,2,4,1),    4'b0111, 0, 0, 0);
    vecs[21] = mk(0, 0, '0,            16'h2CA1, p4(18,2,4,1),   4'b0101, 0, 0, 0);
    vecs[22] = mk(0, 0, '0,            16'h3A12, p4(22,2,4,1),   4'b0001, 0, 1, 0);
    vecs[23] = mk(0, 1, '0,            16'h0000, p4(9,2,5,1),    4'b1111, 0, 0, 0);

    rst_n = 1'b0; start = 1'b0; restart = 1'b0; key = 4'h0; deal = '0;
    tick(); tick();
    check_state("in_reset", '0, 4'b0000, 0, 0);
    check("in_reset.err", 64'(err), 64'd0);
    rst_n = 1'b1;
    tick();
    check_state("after_reset", '0, 4'b0000, 0, 0);

    // Restart and keys are ignored in IDLE.
    base = err_total;
    restart = 1'b1; tick(); restart = 1'b0; tick();
    press(4'h1); press(4'hA); press(4'h2); tick();
    check_state("idle_ignore", '0, 4'b0000, 0, 0);
    check("idle_ignore.err", 64'(err_total - base), 64'd0);

    for (int i = 0; i < 24; i++) run_vec(i, vecs[i]);

    // Start and key in the same cycle: key dropped, held key never re-fires.
    deal = p4(4,6,1,1); start = 1'b1; key = 4'h1; tick(); start = 1'b0;
    repeat (4) tick();
    key = 4'h0; tick();
    press(4'hA); press(4'h2); press(4'hB); press(4'h3); tick();
    check_state("start_key_same", p4(4,5,1,1), 4'b1011, 0, 0);

    // Held key in PICK_A selects once; held key a in PICK_B errs once.
    base = err_total;
    key = 4'h1; repeat (5) tick(); key = 4'h0; tick();
    press(4'hA);
    key = 4'h1; repeat (5) tick(); key = 4'h0; tick();
    press(4'h4); tick();
    check_state("held_key", p4(5,5,1,1), 4'b0011, 0, 0);
    check("held_key.err", 64'(err_total - base), 64'd1);

    // Undo key.
    deal = p4(4,6,1,1); start = 1'b1; tick(); start = 1'b0; tick();
    press(4'h1); press(4'hA); press(4'h2); tick();
    base = err_total;
    press(4'hE); tick();
`ifdef CARD_GAME_UNDO_EN
    check_state("undo1", p4(4,6,1,1), 4'b1111, 0, 0);
    check("undo1.err", 64'(err_total - base), 64'd0);
    base = err_total;
    press(4'hE); tick();
    check_state("undo2", p4(4,6,1,1), 4'b1111, 0, 0);
    check("undo2.err", 64'(err_total - base), 64'd1);
`else
    check_state("undo_off", p4(10,6,1,1), 4'b1101, 0, 0);
    check("undo_off.err", 64'(err_total - base), 64'd0);
`endif

    // Reset during EXEC aborts; start held through release gives one event.
    deal = p4(4,6,1,1); start = 1'b1; tick(); start = 1'b0; tick();
    press(4'h1); press(4'hA);
    key = 4'h2; tick();
    #2 rst_n = 1'b0;
    #1;
    check_state("mid_reset", '0, 4'b0000, 0, 0);
    key = 4'h0; start = 1'b1; deal = p4(3,3,3,3);
    tick();
    rst_n = 1'b1;
    tick();
    check_state("start_through_reset", p4(3,3,3,3), 4'b1111, 0, 0);
    press(4'h1); press(4'hA); press(4'h2); tick();
    check_state("start_held_once", p4(6,3,3,3), 4'b1101, 0, 0);
    start = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/card_game_fsm.md
CARD_GAME_FSM -- requirements
Module: card_game_fsm

Interface
REQ-001 Parameter NUM_CARDS, default 4: number of cards per deal; legal range 2..9.
REQ-002 Parameter WIDTH, default 10: bit width of each card value.
REQ-003 Parameter TARGET, default 24: value that wins when one card remains.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  level; a 0->1 edge begins a new game from the deal bus.
REQ-007 restart  input  1  level; a 0->1 edge reloads the last deal.
REQ-008 key  input  4  decoded keypad code: 0 none, 1..NUM_CARDS select card, 4'hA add, 4'hB sub, 4'hC mul, 4'hD div, 4'hE undo; other values ignored.
REQ-009 deal  input  NUM_CARDS*WIDTH  new card values, card 0 in the LSBs; sampled only on a start event.
REQ-010 nums  output  NUM_CARDS*WIDTH  current card values, card 0 in the LSBs.
REQ-011 valid  output  NUM_CARDS  bit i set = card i still in play.
REQ-012 win  output  1  level; set when the game ends at TARGET.
REQ-013 lose  output  1  level; set when the game ends at any other value.
REQ-014 err  output  1  one-cycle pulse when an operation is rejected.

Function
REQ-015 start, restart and key SHALL be registered each cycle; an event is a 0->1 edge on start or restart, or a key change from 0 to non-zero; held or changing non-zero keys SHALL NOT create events.
REQ-016 Priority within one cycle SHALL be start > restart > key; lower-priority events in that cycle SHALL be dropped.
REQ-017 A start event SHALL load nums and a snapshot register from deal, set valid to all ones, clear win and lose, and enter PICK_A.
REQ-018 A restart event SHALL reload nums from the snapshot, set valid to all ones, clear win and lose, and enter PICK_A; in IDLE it SHALL be ignored.
REQ-019 States SHALL be IDLE, PICK_A, PICK_OP, PICK_B, EXEC and DONE; IDLE and DONE SHALL ignore key events.
REQ-020 PICK_A: a card key for a valid card SHALL latch operand a and go to PICK_OP; any other key SHALL be ignored.
REQ-021 PICK_OP: an op key SHALL latch op and go to PICK_B; a valid card key SHALL re-latch a and stay in PICK_OP.
REQ-022 PICK_B: a valid card key different from a SHALL latch b and go to EXEC; an op key SHALL replace op and stay; key a or an invalid card SHALL pulse err and stay.
REQ-023 EXEC SHALL last exactly one cycle; its result SHALL be visible on nums in the following cycle.
REQ-024 Arithmetic: add, sub and mul SHALL be computed modulo 2^WIDTH with sub = a-b unsigned wrap; div SHALL be unsigned floor a/b.
REQ-025 Division by zero SHALL pulse err, leave nums and valid unchanged, and return to PICK_A.
REQ-026 Otherwise: the result SHALL be written to card min(a,b), valid[max(a,b)] SHALL be cleared, and the FSM SHALL return to PICK_A.
REQ-027 If exactly one card remains valid after the write, the FSM SHALL enter DONE and set win if that card equals TARGET, else set lose.
REQ-028 win and lose SHALL never both be 1, and SHALL hold until a start event, a restart event, or reset.

Reset
REQ-029 On rst_n low: state IDLE; nums, snapshot, valid, win, lose and err all 0; edge registers 0.
REQ-030 Reset asserted mid-operation SHALL abort immediately, with no partial write.
REQ-031 Because the edge registers reset to 0, a start held high through reset release SHALL produce one start event.

Configuration
REQ-032 When CARD_GAME_UNDO_EN is defined, each EXEC SHALL first save nums and valid to an undo buffer (one level deep).
REQ-033 With CARD_GAME_UNDO_EN defined, key 4'hE in PICK_A, PICK_OP, PICK_B or DONE SHALL restore the undo buffer, clear win and lose, enter PICK_A, and then mark the buffer empty.
REQ-034 With CARD_GAME_UNDO_EN defined, 4'hE with an empty buffer SHALL pulse err; start and restart SHALL empty the buffer.
REQ-035 Without CARD_GAME_UNDO_EN, key 4'hE SHALL be ignored and no undo storage SHALL exist.

Verification
REQ-036 Deal {4,6,1,1}: start; keys 1,A,2 -> nums {10,6,1,1}, valid 1101; then 3,C,4 -> card2=1, valid 0101.
REQ-037 Deal {8,3,3,0}: start; keys 2,B,3 -> card1=0; keys 1,C,2 -> card0=0; keys 1,A,... exhausted -> lose=1, win=0 in DONE.
REQ-038 Deal {6,4,0,0}: start; keys 1,D,4 -> err pulses once, nums unchanged, state PICK_A.
REQ-039 Deal {2,3,4,0}: start; keys 2,C,3 -> card1=12; keys 1,C,2 -> card0=24; keys 1,A,4 -> card0=24, valid 0001, win=1; restart -> nums {2,3,4,0}, valid 1111, win=0.
REQ-040 Start and key 1 in the same cycle -> key dropped, state PICK_A; key held at 1 for 5 cycles -> exactly one selection.
REQ-041 With CARD_GAME_UNDO_EN defined: after REQ-036 first op, key E -> nums {4,6,1,1}, valid 1111; a second E -> err pulse.
